// File: rtl/ula_pkg.sv
// Shared widths, result payload and FSM encodings for the subtractor controller.
package ula_pkg;

    localparam int unsigned OP_W  = 8;
    localparam int unsigned N_REQ = 2;
    localparam int unsigned ID_W  = 1;
    localparam int unsigned RES_W = OP_W + 1;

    // Result payload: borrow in the MSB, difference below it.
    typedef struct packed {
        logic            borrow;
        logic [OP_W-1:0] diff;
    } resultado_t;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

endpackage

// File: rtl/controlador_subtrator_if.sv
// Request/result handshake bundle between requesters, consumer and the controller.
interface controlador_subtrator_if;
    import ula_pkg::*;

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*OP_W-1:0] req_a;
    logic [N_REQ*OP_W-1:0] req_b;
    logic                  res_valid;
    logic                  res_ready;
    resultado_t            res_s;
    logic [ID_W-1:0]       res_id;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_s, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_s, res_id
    );

endinterface

// File: rtl/subtrator_completo.sv
// Unsigned 8-bit subtractor producing difference and borrow.
module subtrator_completo
    import ula_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic [OP_W-1:0] diff_c,
    output logic            borrow_c
);

    logic [OP_W:0] ext;

    // Zero-extend so the top bit of the difference is the borrow.
    assign ext      = {1'b0, a} - {1'b0, b};
    assign diff_c   = ext[OP_W-1:0];
    assign borrow_c = ext[OP_W];

endmodule

// File: rtl/controlador_subtrator.sv
// Two-requester subtraction controller: arbitrate, compute, hold result until taken.
// Define SUB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to requester 0.
module controlador_subtrator
    import ula_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    controlador_subtrator_if.slave   bus,
    output logic                     ocupado
);

    estado_t         estado, estado_d;
    logic [ID_W-1:0] grant_c;
    logic            transfer_c;
    logic [N_REQ-1:0] req_ready_c;

    logic [OP_W-1:0] a_sl [N_REQ];
    logic [OP_W-1:0] b_sl [N_REQ];

    logic [OP_W-1:0] op_a, op_b;
    logic [ID_W-1:0] op_id;
    logic [OP_W-1:0] diff_c;
    logic            borrow_c;

    resultado_t      res_s_q;
    logic [ID_W-1:0] res_id_q;
    logic            res_valid_q;

    // Per-requester operand slices.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            a_sl[i] = bus.req_a[i*OP_W +: OP_W];
            b_sl[i] = bus.req_b[i*OP_W +: OP_W];
        end
    end

`ifdef SUB_ROUND_ROBIN_EN
    logic [ID_W-1:0] ultimo;

    // Contention goes to whoever was not served last.
    always_comb begin
        grant_c = bus.req_valid[0] ? ID_W'(0) : ID_W'(1);
        if (&bus.req_valid) grant_c = ~ultimo;
    end

    always_ff @(posedge clk) begin
        if (rst)             ultimo <= ID_W'(1);
        else if (transfer_c) ultimo <= grant_c;
    end
`else
    assign grant_c = bus.req_valid[0] ? ID_W'(0) : ID_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) estado <= OCIOSO;
        else     estado <= estado_d;
    end

    always_comb begin
        estado_d    = estado;
        req_ready_c = '0;
        transfer_c  = 1'b0;
        unique case (estado)
            OCIOSO: begin
                if (!rst) req_ready_c[grant_c] = bus.req_valid[grant_c];
                transfer_c = |req_ready_c;
                if (transfer_c) estado_d = CALCULA;
            end
            CALCULA: estado_d = ENTREGA;
            ENTREGA: if (bus.res_ready) estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    subtrator_completo u_sub (
        .a        (op_a),
        .b        (op_b),
        .diff_c   (diff_c),
        .borrow_c (borrow_c)
    );

    // Operand capture on transfer, result capture in CALCULA, release on consumer take.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a        <= '0;
            op_b        <= '0;
            op_id       <= '0;
            res_s_q     <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            if (transfer_c) begin
                op_a  <= a_sl[grant_c];
                op_b  <= b_sl[grant_c];
                op_id <= grant_c;
            end
            if (estado == CALCULA) begin
                res_s_q     <= '{borrow: borrow_c, diff: diff_c};
                res_id_q    <= op_id;
                res_valid_q <= 1'b1;
            end else if (estado == ENTREGA && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.res_valid = res_valid_q;
    assign bus.res_s     = res_s_q;
    assign bus.res_id    = res_id_q;
    assign ocupado       = (estado != OCIOSO) && !rst;

endmodule

// File: tb/tb_controlador_subtrator.sv
// Scoreboard bench for controlador_subtrator; arbitration expectations follow SUB_ROUND_ROBIN_EN.
module tb_controlador_subtrator;
    import ula_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ocupado;

    controlador_subtrator_if bus ();

    controlador_subtrator dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ocupado (ocupado)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       id;
        logic [8:0] s;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic ult    = 1'b1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        d = a - b;
        return {a < b, d};
    endfunction

    function automatic logic model_grant(input logic [1:0] v);
`ifdef SUB_ROUND_ROBIN_EN
        if (v == 2'b11) return ~ult;
`endif
        return v[0] ? 1'b0 : 1'b1;
    endfunction

    // One complete operation: grant, latency, optional back-pressure, delivery, release.
    task automatic run_op(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0,
                          input logic [7:0] a1, input logic [7:0] b1, input int hold);
        logic       g;
        logic [1:0] want;
        exp_t       e;
        bus.req_valid = v;
        bus.req_a     = {a1, a0};
        bus.req_b     = {b1, b0};
        bus.res_ready = 1'b0;
        #1;
        g    = model_grant(v);
        want = 2'b01 << g;
        checks++;
        if (bus.req_ready !== want) begin
            errors++;
            $display("FAIL grant: req_ready=%b expected %b", bus.req_ready, want);
        end
        e.id = g;
        e.s  = g ? ref_sub(a1, b1) : ref_sub(a0, b0);
        sb.push_back(e);
        ult = g;
        step();
        checks++;
        if (bus.res_valid !== 1'b0 || bus.req_ready !== 2'b00 || ocupado !== 1'b1) begin
            errors++;
            $display("FAIL calcula: res_valid=%b req_ready=%b ocupado=%b expected 0 00 1",
                     bus.res_valid, bus.req_ready, ocupado);
        end
        step();
        checks++;
        if (bus.res_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: res_valid=%b expected 1 two cycles after transfer", bus.res_valid);
        end
        for (int i = 0; i < hold; i++) begin
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_s !== sb[0].s || bus.req_ready !== 2'b00) begin
                errors++;
                $display("FAIL hold[%0d]: res_valid=%b res_s=%h req_ready=%b expected 1 %h 00",
                         i, bus.res_valid, bus.res_s, bus.req_ready, sb[0].s);
            end
            step();
        end
        bus.req_valid = 2'b00;
        bus.res_ready = 1'b1;
        #1;
        e = sb.pop_front();
        checks++;
        if (bus.res_s !== e.s) begin
            errors++;
            $display("FAIL res_s: got %h expected %h", bus.res_s, e.s);
        end
        checks++;
        if (bus.res_id !== e.id) begin
            errors++;
            $display("FAIL res_id: got %0d expected %0d", bus.res_id, e.id);
        end
        step();
        bus.res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || ocupado !== 1'b0 || bus.res_s !== e.s) begin
            errors++;
            $display("FAIL release: res_valid=%b ocupado=%b res_s=%h expected 0 0 %h",
                     bus.res_valid, ocupado, bus.res_s, e.s);
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_a     = 16'h1234;
        bus.req_b     = 16'h5678;
        bus.res_ready = 1'b0;
        step();
        step();
        checks++;
        if (bus.res_valid !== 1'b0 || bus.res_s !== 9'h000 || bus.res_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: res_valid=%b res_s=%h res_id=%b expected 0 000 0",
                     bus.res_valid, bus.res_s, bus.res_id);
        end
        checks++;
        if (bus.req_ready !== 2'b00 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: req_ready=%b ocupado=%b expected 00 0", bus.req_ready, ocupado);
        end
        rst           = 1'b0;
        bus.req_valid = 2'b00;
        ult           = 1'b1;
        step();
    endtask

    task automatic test_basic();
        run_op(2'b01, 8'h05, 8'h03, 8'hAA, 8'h11, 0);
    endtask

    task automatic test_borrow();
        run_op(2'b10, 8'h77, 8'h22, 8'h03, 8'h05, 0);
    endtask

    task automatic test_boundaries();
        run_op(2'b01, 8'h80, 8'h80, 8'h00, 8'h00, 0);
        run_op(2'b01, 8'h00, 8'h01, 8'h00, 8'h00, 0);
        run_op(2'b10, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);
    endtask

    task automatic test_backpressure();
        run_op(2'b01, 8'hFF, 8'h00, 8'h00, 8'h00, 5);
    endtask

    task automatic test_reset_mid();
        bus.req_valid = 2'b01;
        bus.req_a     = 16'h0010;
        bus.req_b     = 16'h0001;
        #1;
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (ocupado !== 1'b0 || bus.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL rst_in_calcula: ocupado=%b req_ready=%b expected 0 00", ocupado, bus.req_ready);
        end
        step();
        rst           = 1'b0;
        bus.req_valid = 2'b00;
        ult           = 1'b1;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.res_s !== 9'h000 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: res_valid=%b res_s=%h ocupado=%b expected 0 000 0",
                     bus.res_valid, bus.res_s, ocupado);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.res_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_result[%0d]: res_valid=%b expected 0", i, bus.res_valid);
            end
            step();
        end
    endtask

    task automatic test_arbitration();
        logic [2:0] ids;
`ifdef SUB_ROUND_ROBIN_EN
        ids = 3'b010;
`else
        ids = 3'b000;
`endif
        for (int k = 0; k < 3; k++) begin
            run_op(2'b11, 8'h20 + 8'(k), 8'h01, 8'h30, 8'h40 + 8'(k), 0);
            checks++;
            if (bus.res_id !== ids[2-k]) begin
                errors++;
                $display("FAIL arb_seq[%0d]: res_id=%0d expected %0d", k, bus.res_id, ids[2-k]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 2'b00;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_borrow();
        test_boundaries();
        test_backpressure();
        test_reset_mid();
        test_arbitration();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
